// File: rtl/dmem_responder_if.sv
// Load/store request bus between the MEM stage (master) and the data-memory responder (slave).
// DMEM_BYTE_EN_EN adds the per-byte store enable req_be.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  req_be;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
`ifdef DMEM_BYTE_EN_EN
        output req_be,
`endif
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
`ifdef DMEM_BYTE_EN_EN
        input  req_be,
`endif
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait WAIT_CYCLES, one-cycle response.
// Optional DMEM_BYTE_EN_EN macro enables byte-masked stores via req_be.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [3:0]       req_be_in;
`ifdef DMEM_BYTE_EN_EN
    assign req_be_in = bus.req_be;
`else
    assign req_be_in = 4'hF;
`endif

    // Request decode, all in 32-bit unsigned arithmetic
    logic [31:0] req_off, req_idx32;
    logic        req_bad;
    always_comb begin
        req_off   = bus.req_addr - ADDR_BASE;
        req_idx32 = req_off >> 2;
        req_bad   = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < ADDR_BASE) ||
                    (req_idx32 >= DEPTH_WORDS);
    end

    // Commit port: the single cycle in which the memory is touched
    logic             c_en, c_wr;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        c_en    = 1'b0;
        c_wr    = wr_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    idx_d   = req_idx32[IDX_W-1:0];
                    wdata_d = bus.req_wdata;
                    be_d    = req_be_in;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: commit on the accept edge itself
                        err_d   = 1'b0;
                        c_en    = 1'b1;
                        c_wr    = bus.req_wr;
                        c_idx   = req_idx32[IDX_W-1:0];
                        c_wdata = bus.req_wdata;
                        c_be    = req_be_in;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    c_en    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (c_en) rdata_d = c_wr ? 32'h0 : mem[c_idx];
    end

    logic        mem_we;
    logic [31:0] mem_wdata;
    always_comb begin
        mem_wdata = mem[c_idx];
        for (int b = 0; b < 4; b++)
            if (c_be[b]) mem_wdata[8*b +: 8] = c_wdata[8*b +: 8];
    end
    assign mem_we = c_en & c_wr & ~rst;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[c_idx] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = (state_q == S_RESP) & err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2, ADDR_BASE=0).
// Byte-enable sequence runs only when DMEM_BYTE_EN_EN is defined.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction; latency counted in cycles after the accept edge
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic err, output logic [31:0] rdata,
                          output int lat, output logic hs_ok);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
        bus.req_be    = be;
`else
        if (be == 4'h0) bus.req_wdata = wdata;
`endif
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_5A5A;
        hs_ok = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.resp_valid && (bus.req_ready || !bus.busy)) hs_ok = 1'b0;
        end while (!bus.resp_valid && lat < 50);
        if (lat >= 50) begin
            errors++;
            $display("FAIL timeout waiting for resp_valid addr=%h", addr);
        end
        err   = bus.resp_err;
        rdata = bus.resp_rdata;
        if (bus.req_ready || !bus.busy) hs_ok = 1'b0;
        @(negedge clk);
        if (bus.resp_valid || !bus.req_ready || bus.busy) hs_ok = 1'b0;
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        int          lat;
        logic        ok;
        int          acc0, acc1;
        logic        seen;

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
        bus.req_be    = 4'hF;
`endif

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          3};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  3};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0,          1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  3};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0,          3};
        vecs[5]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h0,          1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D,  3};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0,          3};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_F00D,  3};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,          1};
        vecs[10] = '{1'b1, 32'h0000_0012, 32'h7777_7777, 1'b1, 32'h0,          1};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'h0);
        chk("rst_busy",       {31'h0, bus.busy},       32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, e, r, lat, ok);
            chk($sformatf("v%0d_lat", i),   lat,             vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i),   {31'h0, e},      {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), r,               vecs[i].exp_rdata);
            chk($sformatf("v%0d_hs", i),    {31'h0, ok},     32'h1);
        end

        // Back-to-back: req_valid held high across two loads
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h10;
        acc0 = -1;
        acc1 = -1;
        ok   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_ready) begin
                if (acc0 < 0) acc0 = c;
                else acc1 = c;
            end else if (!bus.busy) ok = 1'b0;
            if (acc1 >= 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 50);
        chk("b2b_spacing", acc1 - acc0, 4);
        chk("b2b_busy",    {31'h0, ok}, 32'h1);
        chk("b2b_lat",     lat, 3);
        chk("b2b_rdata",   bus.resp_rdata, 32'hDEAD_BEEF);

        // Reset during WAIT discards the pending store
        do_req(1'b1, 32'h20, 32'h0000_0001, 4'hF, e, r, lat, ok);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'h0, bus.req_ready},  32'h1);
        chk("mid_rst_busy",  {31'h0, bus.busy},       32'h0);
        chk("mid_rst_rdata", bus.resp_rdata,          32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", {31'h0, seen}, 32'h0);
        do_req(1'b0, 32'h20, 32'h0, 4'hF, e, r, lat, ok);
        chk("mid_rst_word", r, 32'h0000_0001);

`ifdef DMEM_BYTE_EN_EN
        do_req(1'b1, 32'h40, 32'hAABB_CCDD, 4'hF, e, r, lat, ok);
        do_req(1'b1, 32'h40, 32'h1122_3344, 4'b0011, e, r, lat, ok);
        do_req(1'b0, 32'h40, 32'h0, 4'b0000, e, r, lat, ok);
        chk("be_partial", r, 32'hAABB_3344);
        do_req(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, e, r, lat, ok);
        chk("be_zero_lat", lat, 3);
        chk("be_zero_err", {31'h0, e}, 32'h0);
        do_req(1'b0, 32'h40, 32'h0, 4'b0000, e, r, lat, ok);
        chk("be_zero_word", r, 32'hAABB_3344);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
